// File: rtl/regfile_pkg.sv
// Shared definitions for the register file write-port arbiter.
package regfile_pkg;

  localparam int REGADR_W = 5;
  localparam int XLEN_DEF = 32;

  typedef struct packed {
    logic [REGADR_W-1:0] rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;

  function automatic int numregs(input bit e_supported);
    return e_supported ? 16 : 32;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry result buffer: 1-bit wrapping pointers, separate occupancy count.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  entry_t     din,
  output entry_t     dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  entry_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback with buffered long-latency results onto
// the single regfile write port and tracks pending destinations.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int E_SUPPORTED = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PipeWeW,
  input  logic [REGADR_W-1:0] PipeRdW,
  input  logic [XLEN-1:0]     PipeResultW,
  input  logic                LLIssue,
  input  logic [REGADR_W-1:0] LLIssueRd,
  input  logic                LLValid,
  output logic                LLReady,
  input  logic [REGADR_W-1:0] LLRd,
  input  logic [XLEN-1:0]     LLResult,
  input  logic                LLFlush,
  input  logic [REGADR_W-1:0] Rs1D,
  input  logic [REGADR_W-1:0] Rs2D,
  input  logic [REGADR_W-1:0] RdD,
  output logic                LLHazardD,
  output logic                RegWrite,
  output logic [REGADR_W-1:0] RegWriteAdr,
  output logic [XLEN-1:0]     RegWriteData,
  output logic [1:0]          BufCount
);

  localparam int NUMREGS = numregs(E_SUPPORTED != 0);
  localparam logic [31:0] REG_MASK =
    ((NUMREGS == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF) & ~32'h1;

  typedef struct packed {
    logic [REGADR_W-1:0] rd;
    logic [XLEN-1:0]     data;
  } entry_t;

  // Upper registers don't exist in the embedded profile.
  function automatic logic legal(input logic [REGADR_W-1:0] a);
    return !((E_SUPPORTED != 0) && a[4]);
  endfunction

  entry_t      din;
  entry_t      head;
  logic        full;
  logic        empty;
  logic        pipe_we;
  logic        push;
  logic        pop;
  logic        issue_set;
  logic [31:0] busy;
  logic [31:0] busy_n;

  assign pipe_we = PipeWeW && (PipeRdW != '0)
                && legal(PipeRdW) && !reset;
  assign pop  = !pipe_we && !empty && !LLFlush && !reset;
  assign push = LLValid && LLReady && (LLRd != '0)
             && legal(LLRd) && !LLFlush && !reset;
  assign issue_set = LLIssue && (LLIssueRd != '0)
                  && legal(LLIssueRd);

  assign din = '{rd: LLRd, data: LLResult};

  wb_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (LLFlush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (BufCount)
  );

  assign LLReady = !full;

  always_comb begin
    RegWrite     = 1'b0;
    RegWriteAdr  = '0;
    RegWriteData = '0;
    if (pipe_we) begin
      RegWrite     = 1'b1;
      RegWriteAdr  = PipeRdW;
      RegWriteData = PipeResultW;
    end else if (pop) begin
      RegWrite     = 1'b1;
      RegWriteAdr  = head.rd;
      RegWriteData = head.data;
    end
  end

  // A new issue to the register being retired keeps it busy.
  always_comb begin
    busy_n = busy;
    if (pop) busy_n[head.rd] = 1'b0;
    if (issue_set) busy_n[LLIssueRd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || LLFlush) busy <= '0;
    else busy <= busy_n & REG_MASK;
  end

  assign LLHazardD = busy[Rs1D] | busy[Rs2D] | busy[RdD];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        PipeWeW;
  logic [4:0]  PipeRdW;
  logic [31:0] PipeResultW;
  logic        LLIssue;
  logic [4:0]  LLIssueRd;
  logic        LLValid;
  logic [4:0]  LLRd;
  logic [31:0] LLResult;
  logic        LLFlush;
  logic [4:0]  Rs1D, Rs2D, RdD;

  logic        LLReady, LLHazardD, RegWrite;
  logic [4:0]  RegWriteAdr;
  logic [31:0] RegWriteData;
  logic [1:0]  BufCount;

  logic        e_LLReady, e_LLHazardD, e_RegWrite;
  logic [4:0]  e_RegWriteAdr;
  logic [31:0] e_RegWriteData;
  logic [1:0]  e_BufCount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .E_SUPPORTED(0)) dut (
    .clk(clk), .reset(reset),
    .PipeWeW(PipeWeW), .PipeRdW(PipeRdW), .PipeResultW(PipeResultW),
    .LLIssue(LLIssue), .LLIssueRd(LLIssueRd),
    .LLValid(LLValid), .LLReady(LLReady), .LLRd(LLRd),
    .LLResult(LLResult), .LLFlush(LLFlush),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LLHazardD(LLHazardD),
    .RegWrite(RegWrite), .RegWriteAdr(RegWriteAdr),
    .RegWriteData(RegWriteData), .BufCount(BufCount)
  );

  regfile_wb_arbiter #(.XLEN(32), .E_SUPPORTED(1)) dut_e (
    .clk(clk), .reset(reset),
    .PipeWeW(PipeWeW), .PipeRdW(PipeRdW), .PipeResultW(PipeResultW),
    .LLIssue(LLIssue), .LLIssueRd(LLIssueRd),
    .LLValid(LLValid), .LLReady(e_LLReady), .LLRd(LLRd),
    .LLResult(LLResult), .LLFlush(LLFlush),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LLHazardD(e_LLHazardD),
    .RegWrite(e_RegWrite), .RegWriteAdr(e_RegWriteAdr),
    .RegWriteData(e_RegWriteData), .BufCount(e_BufCount)
  );

  // Reference model (E_SUPPORTED=0 instance): a result queue and busy set.
  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
  } ment_t;

  ment_t     q[$];
  bit [31:0] mbusy;
  bit        x_we, x_rdy, x_haz;
  bit [4:0]  x_adr;
  bit [31:0] x_data;
  int        x_cnt;

  task automatic model_exp();
    bit pw;
    pw = PipeWeW && PipeRdW != 0 && !reset;
    x_we = 0; x_adr = 0; x_data = 0;
    if (pw) begin
      x_we = 1; x_adr = PipeRdW; x_data = PipeResultW;
    end else if (q.size() > 0 && !LLFlush && !reset) begin
      x_we = 1; x_adr = q[0].rd; x_data = q[0].data;
    end
    x_rdy = q.size() < 2;
    x_cnt = q.size();
    x_haz = mbusy[Rs1D] | mbusy[Rs2D] | mbusy[RdD];
  endtask

  task automatic model_clk();
    bit    pw, acc;
    ment_t e;
    if (reset || LLFlush) begin
      q.delete();
      mbusy = 0;
    end else begin
      pw  = PipeWeW && PipeRdW != 0;
      acc = LLValid && q.size() < 2 && LLRd != 0;
      if (!pw && q.size() > 0) begin
        mbusy[q[0].rd] = 0;
        void'(q.pop_front());
      end
      if (acc) begin
        e.rd = LLRd; e.data = LLResult;
        q.push_back(e);
      end
      if (LLIssue && LLIssueRd != 0) mbusy[LLIssueRd] = 1;
    end
  endtask

  task automatic tick();
    model_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PipeWeW = 0; PipeRdW = 0; PipeResultW = 0;
    LLIssue = 0; LLIssueRd = 0;
    LLValid = 0; LLRd = 0; LLResult = 0; LLFlush = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    PipeWeW = 1; PipeRdW = 3; PipeResultW = 32'h1234;
    @(negedge clk);
    tests++;
    if (RegWrite !== 1'b0) begin
      fails++;
      $display("FAIL reset_pipe_sup: RegWrite=%b want 0", RegWrite);
    end
    tick();
    tick();
    reset = 0;
    idle();
    Rs1D = 1; Rs2D = 2; RdD = 3;
    @(negedge clk);
    tests++;
    if (LLReady !== 1'b1 || BufCount !== 2'd0) begin
      fails++;
      $display("FAIL reset_fifo: rdy=%b cnt=%0d want 1/0", LLReady, BufCount);
    end
    tests++;
    if (LLHazardD !== 1'b0 || RegWrite !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: haz=%b we=%b want 0/0", LLHazardD, RegWrite);
    end
    tick();
  endtask

  task automatic test_ll_commit();
    do_reset();
    LLIssue = 1; LLIssueRd = 5;
    tick();
    idle();
    LLValid = 1; LLRd = 5; LLResult = 32'hAB; RdD = 5;
    @(negedge clk);
    tests++;
    if (LLHazardD !== 1'b1 || RegWrite !== 1'b0) begin
      fails++;
      $display("FAIL ll_nobypass: haz=%b we=%b want 1/0", LLHazardD, RegWrite);
    end
    tick();
    LLValid = 0;
    @(negedge clk);
    tests++;
    if (RegWrite !== 1'b1 || RegWriteAdr !== 5'd5 ||
        RegWriteData !== 32'hAB) begin
      fails++;
      $display("FAIL ll_commit: we=%b adr=%0d data=%h want 1/5/ab",
               RegWrite, RegWriteAdr, RegWriteData);
    end
    tick();
    @(negedge clk);
    tests++;
    if (LLHazardD !== 1'b0 || BufCount !== 2'd0) begin
      fails++;
      $display("FAIL ll_busy_clr: haz=%b cnt=%0d want 0/0", LLHazardD, BufCount);
    end
    tick();
  endtask

  task automatic test_pipe_priority();
    do_reset();
    PipeWeW = 1; PipeRdW = 3; PipeResultW = 32'h33;
    LLValid = 1; LLRd = 7; LLResult = 32'h77;
    @(negedge clk);
    tests++;
    if (RegWrite !== 1'b1 || RegWriteAdr !== 5'd3 ||
        RegWriteData !== 32'h33) begin
      fails++;
      $display("FAIL pipe_wins: we=%b adr=%0d data=%h want 1/3/33",
               RegWrite, RegWriteAdr, RegWriteData);
    end
    tick();
    LLRd = 8; LLResult = 32'h88;
    tick();
    LLValid = 0;
    @(negedge clk);
    tests++;
    if (BufCount !== 2'd2 || LLReady !== 1'b0) begin
      fails++;
      $display("FAIL full: cnt=%0d rdy=%b want 2/0", BufCount, LLReady);
    end
    tick();
    PipeWeW = 0;
    @(negedge clk);
    tests++;
    if (RegWriteAdr !== 5'd7 || RegWriteData !== 32'h77) begin
      fails++;
      $display("FAIL drain1: adr=%0d data=%h want 7/77", RegWriteAdr, RegWriteData);
    end
    tick();
    @(negedge clk);
    tests++;
    if (RegWriteAdr !== 5'd8 || RegWriteData !== 32'h88 ||
        BufCount !== 2'd1) begin
      fails++;
      $display("FAIL drain2: adr=%0d data=%h cnt=%0d want 8/88/1",
               RegWriteAdr, RegWriteData, BufCount);
    end
    tick();
    @(negedge clk);
    tests++;
    if (RegWrite !== 1'b0 || BufCount !== 2'd0) begin
      fails++;
      $display("FAIL drained: we=%b cnt=%0d want 0/0", RegWrite, BufCount);
    end
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    LLIssue = 1; LLIssueRd = 9;
    tick();
    idle();
    @(negedge clk);
    tests++;
    if (LLHazardD !== 1'b0) begin
      fails++;
      $display("FAIL haz_x0: haz=%b want 0", LLHazardD);
    end
    Rs1D = 9;
    #1;
    tests++;
    if (LLHazardD !== 1'b1) begin
      fails++;
      $display("FAIL haz_rs1: haz=%b want 1", LLHazardD);
    end
    LLValid = 1; LLRd = 9; LLResult = 32'h99;
    tick();
    LLValid = 0;
    // Head for x9 retires now while x9 is re-issued: must stay busy.
    LLIssue = 1; LLIssueRd = 9;
    @(negedge clk);
    tests++;
    if (LLHazardD !== 1'b1 || RegWriteAdr !== 5'd9) begin
      fails++;
      $display("FAIL haz_pending: haz=%b adr=%0d want 1/9", LLHazardD, RegWriteAdr);
    end
    tick();
    LLIssue = 0;
    @(negedge clk);
    tests++;
    if (LLHazardD !== 1'b1) begin
      fails++;
      $display("FAIL set_wins: haz=%b want 1", LLHazardD);
    end
    LLValid = 1;
    tick();
    LLValid = 0;
    tick();
    @(negedge clk);
    tests++;
    if (LLHazardD !== 1'b0) begin
      fails++;
      $display("FAIL haz_clear: haz=%b want 0", LLHazardD);
    end
    tick();
  endtask

  task automatic test_full_pop();
    do_reset();
    PipeWeW = 1; PipeRdW = 1; PipeResultW = 32'h1;
    LLValid = 1; LLRd = 10; LLResult = 32'hA0;
    tick();
    LLRd = 11; LLResult = 32'hB0;
    tick();
    PipeWeW = 0;
    LLRd = 12; LLResult = 32'hC0;
    @(negedge clk);
    tests++;
    if (LLReady !== 1'b0 || RegWriteAdr !== 5'd10) begin
      fails++;
      $display("FAIL full_pop: rdy=%b adr=%0d want 0/10", LLReady, RegWriteAdr);
    end
    tick();
    @(negedge clk);
    tests++;
    if (LLReady !== 1'b1 || BufCount !== 2'd1 || RegWriteAdr !== 5'd11) begin
      fails++;
      $display("FAIL retry: rdy=%b cnt=%0d adr=%0d want 1/1/11",
               LLReady, BufCount, RegWriteAdr);
    end
    tick();
    LLValid = 0;
    @(negedge clk);
    tests++;
    if (BufCount !== 2'd1 || RegWriteAdr !== 5'd12 ||
        RegWriteData !== 32'hC0) begin
      fails++;
      $display("FAIL pushpop: cnt=%0d adr=%0d data=%h want 1/12/c0",
               BufCount, RegWriteAdr, RegWriteData);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    PipeWeW = 1; PipeRdW = 1; PipeResultW = 32'h1;
    LLIssue = 1; LLIssueRd = 4;
    tick();
    LLIssueRd = 6;
    LLValid = 1; LLRd = 4; LLResult = 32'h44;
    tick();
    LLIssue = 0;
    LLRd = 6; LLResult = 32'h66;
    tick();
    LLValid = 0;
    PipeRdW = 2; PipeResultW = 32'h22;
    LLFlush = 1; Rs1D = 4; Rs2D = 6;
    @(negedge clk);
    tests++;
    if (BufCount !== 2'd2 || RegWriteAdr !== 5'd2 ||
        RegWriteData !== 32'h22) begin
      fails++;
      $display("FAIL flush_pipe: cnt=%0d adr=%0d data=%h want 2/2/22",
               BufCount, RegWriteAdr, RegWriteData);
    end
    tick();
    LLFlush = 0; PipeWeW = 0;
    @(negedge clk);
    tests++;
    if (BufCount !== 2'd0 || LLHazardD !== 1'b0 || RegWrite !== 1'b0) begin
      fails++;
      $display("FAIL flushed: cnt=%0d haz=%b we=%b want 0/0/0",
               BufCount, LLHazardD, RegWrite);
    end
    LLValid = 1; LLRd = 4; LLResult = 32'h45;
    tick();
    LLValid = 0; LLFlush = 1;
    @(negedge clk);
    tests++;
    if (RegWrite !== 1'b0) begin
      fails++;
      $display("FAIL flush_nowb: we=%b want 0", RegWrite);
    end
    tick();
    idle();
  endtask

  task automatic test_e_supported();
    do_reset();
    LLValid = 1; LLRd = 20; LLResult = 32'h2020;
    PipeWeW = 1; PipeRdW = 17; PipeResultW = 32'h1717;
    LLIssue = 1; LLIssueRd = 20;
    @(negedge clk);
    tests++;
    if (e_RegWrite !== 1'b0 || e_LLReady !== 1'b1) begin
      fails++;
      $display("FAIL e_sup_wr: we=%b rdy=%b want 0/1", e_RegWrite, e_LLReady);
    end
    tick();
    idle();
    Rs1D = 20; RdD = 20;
    @(negedge clk);
    tests++;
    if (e_BufCount !== 2'd0 || e_RegWrite !== 1'b0 ||
        e_LLHazardD !== 1'b0) begin
      fails++;
      $display("FAIL e_sup_drop: cnt=%0d we=%b haz=%b want 0/0/0",
               e_BufCount, e_RegWrite, e_LLHazardD);
    end
    LLIssue = 1; LLIssueRd = 5;
    tick();
    idle();
    RdD = 5;
    @(negedge clk);
    tests++;
    if (e_LLHazardD !== 1'b1) begin
      fails++;
      $display("FAIL e_legal_busy: haz=%b want 1", e_LLHazardD);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      PipeWeW     = $urandom_range(0, 1);
      PipeRdW     = 5'($urandom_range(0, 31));
      PipeResultW = $urandom;
      LLIssue     = ($urandom_range(0, 2) == 0);
      LLIssueRd   = 5'($urandom_range(0, 7));
      LLValid     = $urandom_range(0, 1);
      LLRd        = 5'($urandom_range(0, 7));
      LLResult    = $urandom;
      LLFlush     = ($urandom_range(0, 29) == 0);
      Rs1D        = 5'($urandom_range(0, 7));
      Rs2D        = 5'($urandom_range(0, 7));
      RdD         = 5'($urandom_range(0, 7));
      @(negedge clk);
      model_exp();
      tests++;
      if (RegWrite !== x_we || RegWriteAdr !== x_adr ||
          RegWriteData !== x_data) begin
        fails++;
        $display("FAIL rnd_wb[%0d]: got %b/%0d/%h want %b/%0d/%h", i,
                 RegWrite, RegWriteAdr, RegWriteData, x_we, x_adr, x_data);
      end
      tests++;
      if (LLReady !== x_rdy || BufCount !== 2'(x_cnt)) begin
        fails++;
        $display("FAIL rnd_fifo[%0d]: rdy=%b cnt=%0d want %b/%0d", i,
                 LLReady, BufCount, x_rdy, x_cnt);
      end
      tests++;
      if (LLHazardD !== x_haz) begin
        fails++;
        $display("FAIL rnd_haz[%0d]: haz=%b want %b", i, LLHazardD, x_haz);
      end
      tick();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    q.delete();
    mbusy = 0;
    #1;
    test_reset();
    test_ll_commit();
    test_pipe_priority();
    test_hazard();
    test_full_pop();
    test_flush();
    test_e_supported();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
